// File: rtl/alu_multicycle.sv
// Execution ALU for the MIPS datapath: single-cycle logic/arith/shift/compare ops,
// plus iterative shift-add MUL and restoring DIV under a start/busy/done handshake.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             zero,
   output logic             ovf
);

   localparam int CNTW = $clog2(WIDTH);
   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_NOR = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd7;
   localparam logic [3:0] OP_SRL = 4'd8;
   localparam logic [3:0] OP_SLT = 4'd9;
   localparam logic [3:0] OP_XOR = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;

   // Iteration datapath, not reset: always reloaded at accept.
   logic [WIDTH-1:0]  mcand_q, mplier_q, acc_q;
   logic [WIDTH-1:0]  quot_q, divisor_q, prem_q;

   logic              accept;
   logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
   logic [WIDTH-1:0]  sc_res;
   logic              sc_ovf;
   logic [WIDTH-1:0]  mul_acc_nxt;
   logic [WIDTH:0]    div_shift, div_diff;
   logic              div_ge;
   logic [WIDTH-1:0]  prem_nxt, quot_nxt;

   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   assign busy   = (state_q != S_IDLE);
   assign accept = start && !busy;

   assign a_s    = a;
   assign b_s    = b;
   assign sum_s  = a_s + b_s;
   assign diff_s = a_s - b_s;

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (alu_op)
         OP_ADD: begin
            sc_res = sum_s;
            sc_ovf = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff_s;
            sc_ovf = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1]);
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_NOR: sc_res = ~(a | b);
         OP_SLL: sc_res = b << shamt;
         OP_SRL: sc_res = b >> shamt;
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_XOR: sc_res = a ^ b;
         default: sc_res = '0;
      endcase
   end

   assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Restoring step: the shifted partial remainder needs one extra bit before the compare.
   assign div_shift = {prem_q, quot_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, divisor_q};
   assign div_ge    = !div_diff[WIDTH];
   assign prem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign quot_nxt  = {quot_q[WIDTH-2:0], div_ge};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      rem_d    = rem_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (alu_op == OP_MUL) begin
                  state_d = S_MUL;
               end else if (alu_op == OP_DIV) begin
                  state_d = S_DIV;
               end else begin
                  done_d   = 1'b1;
                  result_d = sc_res;
                  rem_d    = '0;
                  zero_d   = (sc_res == '0);
                  ovf_d    = sc_ovf;
               end
            end
         end
         S_MUL: begin
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               done_d   = 1'b1;
               result_d = mul_acc_nxt;
               rem_d    = '0;
               zero_d   = (mul_acc_nxt == '0);
               ovf_d    = 1'b0;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               done_d   = 1'b1;
               result_d = quot_nxt;
               rem_d    = prem_nxt;
               zero_d   = (quot_nxt == '0);
               ovf_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         rem_q    <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mcand_q   <= a;
         mplier_q  <= b;
         acc_q     <= '0;
         quot_q    <= a;
         divisor_q <= b;
         prem_q    <= '0;
      end else if (state_q == S_MUL) begin
         acc_q    <= mul_acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end else if (state_q == S_DIV) begin
         prem_q <= prem_nxt;
         quot_q <= quot_nxt;
      end
   end

   assign done      = done_q;
   assign result    = result_q;
   assign remainder = rem_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;

endmodule
